score_keeper: RTL and testbench

Parametrised game timer and score keeper for the maze game. Counts elapsed time in ticks while a game runs and presents a count-down score. Handles three end/penalty events: win, hole hit and timeout. Sits between the game-logic FSM (start/won/hole strobes) and the seven-segment/VGA score display, and can optionally track the best score across games.

---
 rtl/score_keeper.sv | 180 ++++++++++++++++++
 tb/tb_score_keeper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: game timer and count-down score for the maze game.
//
// Counts elapsed time in ticks while a game runs. score is SCORE_MAX - elapsed.
// The game ends on a win (WON) or when elapsed reaches SCORE_MAX (TIMEOUT).
// A hole either restarts the timer (HOLE_MODE 0) or adds HOLE_PENALTY (HOLE_MODE 1).
//
// Optional feature: define SCORE_BEST_EN to track the best winning score.
// Without it, best_score and new_best are tied to 0.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               strobe: begin a new game (from IDLE, WON or TIMEOUT)
//   won_the_game        ball reached the goal (honoured only in RUN)
//   hit_a_hole          strobe: ball fell in a hole (honoured only in RUN)
//   pause               level: freeze the tick divider while high
//   score               SCORE_MAX - elapsed (combinational from the elapsed register)
//   elapsed             elapsed time units
//   state               0 IDLE, 1 RUN, 2 WON, 3 TIMEOUT (FSM debug/observation)
//   timeout             high while in TIMEOUT
//   done                one-cycle pulse on entering WON or TIMEOUT
//   best_score          best winning score so far
//   new_best            one-cycle pulse when best_score is updated
//
// Event handshake: start, won_the_game and hit_a_hole are sampled on each
// rising clk edge with no back-pressure. In RUN the priority within one cycle
// is won_the_game > hit_a_hole > tick.
module score_keeper #(
  parameter int CLK_FREQ     = 100000000,
  parameter int TICK_RATE    = 20,
  parameter int SCORE_W      = 16,
  parameter int SCORE_MAX    = 65000,
  parameter int STEP         = 2,
  parameter int HOLE_MODE    = 0,
  parameter int HOLE_PENALTY = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               won_the_game,
  input  logic               hit_a_hole,
  input  logic               pause,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] elapsed,
  output logic [1:0]         state,
  output logic               timeout,
  output logic               done,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_best
);

  localparam int TICK_DIV = CLK_FREQ / TICK_RATE;
  localparam int DIV_W    = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] MAX_W    = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W:0]   MAX_EXT  = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [SCORE_W:0]   STEP_EXT = (SCORE_W+1)'(STEP);
  localparam logic [SCORE_W:0]   PEN_EXT  = (SCORE_W+1)'(HOLE_PENALTY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WON     = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_elapsed, w_elapsed_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_done, r_timeout;
  logic               w_tick, w_inc, w_end_evt;
  logic [SCORE_W:0]   w_add, w_sum;

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_elapsed_nxt = r_elapsed;
    w_div_nxt     = r_div;
    w_inc         = 1'b0;
    w_add         = '0;
    w_sum         = '0;
    w_tick        = (r_state == S_RUN) && !pause && (r_div == DIV_LAST);

    case (r_state)
      S_RUN: begin
        if (!pause) begin
          w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
        if (won_the_game) begin
          // Elapsed freezes; a coincident tick is dropped.
          w_state_nxt = S_WON;
        end else begin
          if (hit_a_hole) begin
            if (HOLE_MODE == 0) begin
              w_elapsed_nxt = '0;
              w_div_nxt     = '0;
            end else begin
              w_inc = 1'b1;
              w_add = PEN_EXT;
            end
          end else if (w_tick) begin
            w_inc = 1'b1;
            w_add = STEP_EXT;
          end
          // One extra bit so the sum can never wrap before the clamp.
          w_sum = {1'b0, r_elapsed} + w_add;
          if (w_inc) begin
            w_elapsed_nxt = (w_sum >= MAX_EXT) ? MAX_W : w_sum[SCORE_W-1:0];
          end
          if (w_elapsed_nxt == MAX_W) begin
            w_state_nxt = S_TIMEOUT;
          end
        end
      end
      default: begin
        // IDLE, WON and TIMEOUT all start a fresh game directly.
        if (start) begin
          w_state_nxt   = S_RUN;
          w_elapsed_nxt = '0;
          w_div_nxt     = '0;
        end
      end
    endcase

    w_end_evt = (r_state == S_RUN) &&
                ((w_state_nxt == S_WON) || (w_state_nxt == S_TIMEOUT));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_elapsed <= '0;
      r_div     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_div     <= w_div_nxt;
      r_done    <= w_end_evt;
      r_timeout <= (w_state_nxt == S_TIMEOUT);
    end
  end

  assign score   = MAX_W - r_elapsed;
  assign elapsed = r_elapsed;
  assign state   = r_state;
  assign timeout = r_timeout;
  assign done    = r_done;

`ifdef SCORE_BEST_EN
  logic               w_win_evt;
  logic [SCORE_W-1:0] r_best;
  logic               r_new_best;

  // score is already frozen when the win is taken, so compare it directly.
  assign w_win_evt = (r_state == S_RUN) && (w_state_nxt == S_WON);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_best     <= '0;
      r_new_best <= 1'b0;
    end else begin
      r_new_best <= 1'b0;
      if (w_win_evt && (score > r_best)) begin
        r_best     <= score;
        r_new_best <= 1'b1;
      end
    end
  end

  assign best_score = r_best;
  assign new_best   = r_new_best;
`else
  assign best_score = '0;
  assign new_best   = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper. Two instances share all inputs: u_dut0 uses
// HOLE_MODE 0 (hole restarts the timer), u_dut1 uses HOLE_MODE 1 (hole adds a
// penalty). Parameters: TICK_DIV 10, SCORE_MAX 20, STEP 2, HOLE_PENALTY 5.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_score_keeper;

`ifdef SCORE_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic        clk, reset, start, won, hole, pause;
  logic [15:0] score0, elapsed0, best0, score1, elapsed1, best1;
  logic [1:0]  state0, state1;
  logic        timeout0, done0, nb0, timeout1, done1, nb1;

  int n_checks = 0;
  int n_fail   = 0;

  score_keeper #(
    .CLK_FREQ(100), .TICK_RATE(10), .SCORE_W(16), .SCORE_MAX(20),
    .STEP(2), .HOLE_MODE(0), .HOLE_PENALTY(5)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .won_the_game(won),
    .hit_a_hole(hole), .pause(pause), .score(score0), .elapsed(elapsed0),
    .state(state0), .timeout(timeout0), .done(done0),
    .best_score(best0), .new_best(nb0)
  );

  score_keeper #(
    .CLK_FREQ(100), .TICK_RATE(10), .SCORE_W(16), .SCORE_MAX(20),
    .STEP(2), .HOLE_MODE(1), .HOLE_PENALTY(5)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .won_the_game(won),
    .hit_a_hole(hole), .pause(pause), .score(score1), .elapsed(elapsed1),
    .state(state1), .timeout(timeout1), .done(done1),
    .best_score(best1), .new_best(nb1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; won = 1'b0; hole = 1'b0; pause = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  // Scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: start a game from WON/IDLE, win after 'ticks' ticks, check best.
  task automatic play_win(input int ticks, input int exp_best, input int exp_nb);
    start = 1'b1; step(1); start = 1'b0;
    step(10 * ticks);
    won = 1'b1; step(1); won = 1'b0;
    chk("best_state", state0, 2);
    chk("best_score_frozen", score0, 20 - 2 * ticks);
    chk("best_done", done0, 1);
    chk("best_value", best0, BEST_EN ? exp_best : 0);
    chk("best_new_best", nb0, BEST_EN ? exp_nb : 0);
    step(1);
    chk("best_new_best_clear", nb0, 0);
    chk("best_value_hold", best1, BEST_EN ? exp_best : 0);
  endtask

  typedef struct {
    int   n;
    logic st, wn, hl, ps;
    int   exp_state, exp_score0, exp_score1, exp_done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Table: hold inputs for n cycles, then compare.
    vecs[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1, 20, 20, 0}; // start
    vecs[1] = '{39, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 14, 0}; // 3 ticks, divider at 9
    vecs[2] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 2, 14, 14, 1}; // win beats coincident tick
    vecs[3] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 2, 14, 14, 0}; // done is one cycle
    vecs[4] = '{50, 1'b0, 1'b1, 1'b1, 1'b0, 2, 14, 14, 0}; // WON ignores won/hole
    vecs[5] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1, 20, 20, 0}; // restart from WON
    vecs[6] = '{20, 1'b0, 1'b0, 1'b0, 1'b0, 1, 16, 16, 0}; // 2 ticks
    vecs[7] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1, 20, 11, 0}; // hole: restart vs +5
    vecs[8] = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 1, 20, 9,  0}; // mode1 ticks on schedule
    vecs[9] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1, 18, 9,  0}; // mode0 tick 10 cycles after hole

    do_reset();
    chk("rst_state", state0, 0);
    chk("rst_score", score0, 20);
    chk("rst_elapsed", elapsed0, 0);
    chk("rst_done", done0, 0);
    chk("rst_timeout", timeout0, 0);
    chk("rst_best", best0, 0);
    chk("rst_new_best", nb0, 0);

    // IDLE ignores won and hole
    won = 1'b1; hole = 1'b1; step(3); won = 1'b0; hole = 1'b0;
    chk("idle_state", state0, 0);
    chk("idle_state1", state1, 0);
    chk("idle_score1", score1, 20);

    for (int i = 0; i < 10; i++) begin
      start = vecs[i].st; won = vecs[i].wn; hole = vecs[i].hl; pause = vecs[i].ps;
      step(vecs[i].n);
      chk($sformatf("vec%0d_state0", i), state0, vecs[i].exp_state);
      chk($sformatf("vec%0d_state1", i), state1, vecs[i].exp_state);
      chk($sformatf("vec%0d_score0", i), score0, vecs[i].exp_score0);
      chk($sformatf("vec%0d_score1", i), score1, vecs[i].exp_score1);
      chk($sformatf("vec%0d_done0", i), done0, vecs[i].exp_done);
      chk($sformatf("vec%0d_done1", i), done1, vecs[i].exp_done);
    end
    start = 1'b0; won = 1'b0; hole = 1'b0; pause = 1'b0;

    // Full count-down to TIMEOUT
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    for (int k = 2; k <= 101; k++) begin
      step(1);
      chk($sformatf("cd_score_c%0d", k), score0, 20 - 2 * ((k - 1) / 10));
      chk($sformatf("cd_state_c%0d", k), state0, (k == 101) ? 3 : 1);
      chk($sformatf("cd_done_c%0d", k), done0, (k == 101) ? 1 : 0);
      chk($sformatf("cd_timeout_c%0d", k), timeout0, (k == 101) ? 1 : 0);
    end
    for (int k = 0; k < 100; k++) begin
      step(1);
      chk("to_score_hold", score0, 0);
      chk("to_done_low", done0, 0);
    end
    chk("to_state", state0, 3);
    chk("to_score1", score1, 0);

    // Penalty saturation: elapsed 18 + 5 clamps to 20
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    hole = 1'b1; step(2); hole = 1'b0;
    chk("sat_two_holes", elapsed1, 10);
    step(38);
    chk("sat_pre_score", score1, 2);
    hole = 1'b1; step(1); hole = 1'b0;
    chk("sat_state", state1, 3);
    chk("sat_score", score1, 0);
    chk("sat_elapsed", elapsed1, 20);
    chk("sat_done", done1, 1);
    chk("sat_timeout", timeout1, 1);
    step(1);
    chk("sat_done_clear", done1, 0);
    chk("sat_state_hold", state1, 3);

    // Pause with divider at 4 for 47 cycles
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    step(4);
    pause = 1'b1; step(47);
    chk("pause_score", score0, 20);
    chk("pause_state", state0, 1);
    pause = 1'b0; step(5);
    chk("pause_pre_tick", score0, 20);
    step(1);
    chk("pause_tick", score0, 18);
    chk("pause_tick1", score1, 18);

    // Hole and tick in the same cycle at elapsed 4
    do_reset();
    start = 1'b1; step(1); start = 1'b0;
    step(29);
    chk("ht_pre", score1, 16);
    hole = 1'b1; step(1); hole = 1'b0;
    chk("ht_elapsed1", elapsed1, 9);
    chk("ht_score1", score1, 11);
    chk("ht_elapsed0", elapsed0, 0);

    // Best score tracking
    do_reset();
    play_win(3, 14, 1);
    play_win(5, 14, 0);
    play_win(2, 16, 1);
    play_win(2, 16, 0);
    do_reset();
    chk("best_after_reset", best0, 0);

    // Reset mid-game
    start = 1'b1; step(1); start = 1'b0;
    step(15);
    chk("mid_pre", score0, 18);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("mid_state", state0, 0);
    chk("mid_score", score0, 20);
    chk("mid_done", done0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
